dwc_error_responder: RTL and testbench
======================================

Name: dwc_error_responder

Overview:
Sequential response end of the duplication-with-comparison (DwC) scheme. It receives the two redundant copies of a datapath result and compares them each valid cycle. On agreement it forwards the value. On mismatch it requests recomputation with a bounded number of retries, and escalates to a sticky fault if the copies keep disagreeing. It sits between a duplicated DwC datapath and downstream logic and system fault handling.

Parameters:
WIDTH, 1, width of each redundant copy and of the forwarded result
MAX_RETRY, 3, number of retry requests issued before escalating to FAULT (0 allowed)
CNT_WIDTH, 8, width of the saturating mismatch counter

Ports:
port_clk  input  1  single clock, rising edge
port_rst_n  input  1  reset, asynchronous, active-low
port_valid  input  1  port_dwc_0/port_dwc_1 carry a sample this cycle
port_dwc_0  input  WIDTH  primary copy
port_dwc_1  input  WIDTH  redundant copy
port_clear  input  1  clears fault, counters and retry state
port_out  output  WIDTH  last agreed (good) value
port_out_valid  output  1  one-cycle pulse: port_out updated with a new agreed value
port_retry  output  1  one-cycle pulse: recompute request to upstream
port_error  output  1  one-cycle pulse: a mismatch was sampled
port_fault  output  1  sticky fault, high while in FAULT
port_err_count  output  CNT_WIDTH  saturating count of sampled mismatches
port_state  output  2  state encoding: 0 OK, 1 RETRY, 2 FAULT

Behaviour:
- Reset is asynchronous and active-low. While port_rst_n=0: state=OK, retry_cnt=0, and every output is 0. Reset asserted mid-retry or in FAULT aborts immediately to these values.
- Mismatch is defined as OR-reduce(port_dwc_0 XOR port_dwc_1). It is evaluated only when port_valid=1.
- All outputs are registered. Latency from a sampled input to its response is 1 cycle.
- port_out changes only on a matching sample and otherwise holds the last good value.
- Per sampled mismatch, in any state: port_error pulses and port_err_count increments. The counter saturates at 2^CNT_WIDTH-1 and never wraps.
- OK state:
  - valid & match: port_out<=port_dwc_0, port_out_valid pulses.
  - valid & mismatch with MAX_RETRY=0: go to FAULT.
  - valid & mismatch with MAX_RETRY>0: retry_cnt<=1, port_retry pulses, go to RETRY.
- RETRY state:
  - No valid: hold state, no pulses.
  - valid & match: deliver as in OK, retry_cnt<=0, go to OK.
  - valid & mismatch with retry_cnt==MAX_RETRY: go to FAULT, no retry pulse.
  - valid & mismatch otherwise: retry_cnt++, port_retry pulses, stay in RETRY.
- Escalation count: FAULT is reached after MAX_RETRY+1 consecutive mismatching samples, with exactly MAX_RETRY retry pulses issued.
- FAULT state:
  - port_fault=1.
  - port_out_valid and port_retry stay 0; port_out is frozen.
  - Mismatches still pulse port_error and increment the counter.
  - FAULT is left only via port_clear (or reset).
- port_clear, any state: next cycle state=OK, retry_cnt=0, port_err_count=0, port_fault=0.
  - port_clear has priority over port_valid in the same cycle; that sample is dropped and produces no pulses.
  - port_out keeps its value through a clear.
- Reads of port_dwc_* with port_valid=0 have no effect.

Test Plan:
- Reset, WIDTH=4: release reset with no stimulus -> all outputs 0, port_state=0.
- Agreeing sample: valid, dwc_0=dwc_1=4'hA -> next cycle port_out=4'hA, port_out_valid pulse, port_err_count=0.
- Single glitch, MAX_RETRY=2: valid 4'h3/4'h7, then valid 4'h5/4'h5 -> error and retry pulses, state=1; then port_out=5, state=0, count=1.
- Escalation, MAX_RETRY=2: three consecutive valid mismatches -> 2 retry pulses, 3 error pulses, port_fault=1, state=2, count=3, port_out unchanged.
- FAULT persistence and clear: in FAULT, matching valid 4'h9/4'h9 -> no out_valid, port_out unchanged; then port_clear together with valid -> state=0, count=0, fault=0, no pulses from that sample.
- Saturation and edge cases, CNT_WIDTH=2: 5 mismatches in FAULT -> count stays 3. MAX_RETRY=0: first mismatch -> FAULT directly, no retry pulse. Assert reset mid-RETRY -> all outputs 0 immediately.

Source files
------------

// File: rtl/dwc_error_responder.sv
// dwc_error_responder: compares two redundant result copies, forwards agreed
// values, requests bounded recomputation on mismatch, escalates to sticky FAULT.
// Ports:
//   port_clk, port_rst_n        clock, async active-low reset
//   port_valid, port_dwc_0/1    sample strobe and the two redundant copies
//   port_clear                  drops fault, counters and retry state
//   port_out, port_out_valid    last agreed value, pulse on update
//   port_retry, port_error      recompute request pulse, mismatch pulse
//   port_fault, port_err_count  sticky fault, saturating mismatch count
//   port_state                  0 OK, 1 RETRY, 2 FAULT
module dwc_error_responder #(
  parameter int WIDTH     = 1,
  parameter int MAX_RETRY = 3,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 port_clk,
  input  logic                 port_rst_n,
  input  logic                 port_valid,
  input  logic [WIDTH-1:0]     port_dwc_0,
  input  logic [WIDTH-1:0]     port_dwc_1,
  input  logic                 port_clear,
  output logic [WIDTH-1:0]     port_out,
  output logic                 port_out_valid,
  output logic                 port_retry,
  output logic                 port_error,
  output logic                 port_fault,
  output logic [CNT_WIDTH-1:0] port_err_count,
  output logic [1:0]           port_state
);

  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  typedef enum logic [1:0] {
    ST_OK    = 2'd0,
    ST_RETRY = 2'd1,
    ST_FAULT = 2'd2
  } state_t;

  state_t               r_state;
  logic [RW-1:0]        r_retry_cnt;
  logic [WIDTH-1:0]     r_out;
  logic                 r_out_valid;
  logic                 r_retry;
  logic                 r_error;
  logic                 r_fault;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic                 w_mismatch;

  assign w_mismatch = |(port_dwc_0 ^ port_dwc_1);

  always_ff @(posedge port_clk or negedge port_rst_n) begin
    if (!port_rst_n) begin
      r_state     <= ST_OK;
      r_retry_cnt <= '0;
      r_out       <= '0;
      r_out_valid <= 1'b0;
      r_retry     <= 1'b0;
      r_error     <= 1'b0;
      r_fault     <= 1'b0;
      r_cnt       <= '0;
    end else begin
      r_out_valid <= 1'b0;
      r_retry     <= 1'b0;
      r_error     <= 1'b0;
      // clear wins over a same-cycle sample, which is dropped
      if (port_clear) begin
        r_state     <= ST_OK;
        r_retry_cnt <= '0;
        r_fault     <= 1'b0;
        r_cnt       <= '0;
      end else if (port_valid) begin
        if (w_mismatch) begin
          r_error <= 1'b1;
          if (r_cnt != {CNT_WIDTH{1'b1}})
            r_cnt <= r_cnt + CNT_WIDTH'(1);
          unique case (r_state)
            ST_OK: begin
              if (MAX_RETRY == 0) begin
                r_state <= ST_FAULT;
                r_fault <= 1'b1;
              end else begin
                r_retry_cnt <= RW'(1);
                r_retry     <= 1'b1;
                r_state     <= ST_RETRY;
              end
            end
            ST_RETRY: begin
              if (r_retry_cnt == RW'(MAX_RETRY)) begin
                r_state <= ST_FAULT;
                r_fault <= 1'b1;
              end else begin
                r_retry_cnt <= r_retry_cnt + RW'(1);
                r_retry     <= 1'b1;
              end
            end
            default: ;
          endcase
        end else if (r_state != ST_FAULT) begin
          r_out       <= port_dwc_0;
          r_out_valid <= 1'b1;
          r_retry_cnt <= '0;
          r_state     <= ST_OK;
        end
      end
    end
  end

  assign port_out       = r_out;
  assign port_out_valid = r_out_valid;
  assign port_retry     = r_retry;
  assign port_error     = r_error;
  assign port_fault     = r_fault;
  assign port_err_count = r_cnt;
  assign port_state     = r_state;

endmodule

// File: tb/tb_dwc_error_responder.sv
// tb_dwc_error_responder: directed bench for dwc_error_responder.
// Instance a: WIDTH=4 MAX_RETRY=2 CNT_WIDTH=2; instance b: MAX_RETRY=0.
module tb_dwc_error_responder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       valid_a, clear_a, valid_b, clear_b;
  logic [3:0] d0, d1;

  logic [3:0] a_out;
  logic       a_ov, a_retry, a_err, a_fault;
  logic [1:0] a_cnt;
  logic [1:0] a_state;

  logic [3:0] b_out;
  logic       b_ov, b_retry, b_err, b_fault;
  logic [7:0] b_cnt;
  logic [1:0] b_state;

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  dwc_error_responder #(.WIDTH(4), .MAX_RETRY(2), .CNT_WIDTH(2)) u_a (
    .port_clk(clk), .port_rst_n(rst_n), .port_valid(valid_a),
    .port_dwc_0(d0), .port_dwc_1(d1), .port_clear(clear_a),
    .port_out(a_out), .port_out_valid(a_ov), .port_retry(a_retry),
    .port_error(a_err), .port_fault(a_fault),
    .port_err_count(a_cnt), .port_state(a_state)
  );

  dwc_error_responder #(.WIDTH(4), .MAX_RETRY(0), .CNT_WIDTH(8)) u_b (
    .port_clk(clk), .port_rst_n(rst_n), .port_valid(valid_b),
    .port_dwc_0(d0), .port_dwc_1(d1), .port_clear(clear_b),
    .port_out(b_out), .port_out_valid(b_ov), .port_retry(b_retry),
    .port_error(b_err), .port_fault(b_fault),
    .port_err_count(b_cnt), .port_state(b_state)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] x0,
                       input logic [3:0] x1, input logic c);
    valid_a = v;
    d0      = x0;
    d1      = x1;
    clear_a = c;
    tick();
  endtask

  // out, out_valid, retry, error, fault, count, state
  task automatic chk_a(input string tag, input logic [3:0] o,
                       input logic ov, input logic rt, input logic er,
                       input logic ft, input logic [1:0] c,
                       input logic [1:0] s);
    chk({tag, ".out"},   32'(a_out),   32'(o));
    chk({tag, ".ov"},    32'(a_ov),    32'(ov));
    chk({tag, ".retry"}, 32'(a_retry), 32'(rt));
    chk({tag, ".err"},   32'(a_err),   32'(er));
    chk({tag, ".fault"}, 32'(a_fault), 32'(ft));
    chk({tag, ".cnt"},   32'(a_cnt),   32'(c));
    chk({tag, ".state"}, 32'(a_state), 32'(s));
  endtask

  initial begin
    rst_n   = 1'b0;
    valid_a = 1'b0;
    clear_a = 1'b0;
    valid_b = 1'b0;
    clear_b = 1'b0;
    d0      = 4'h0;
    d1      = 4'h0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk_a("reset", 4'h0, 0, 0, 0, 0, 2'd0, 2'd0);
    chk("reset.b_state", 32'(b_state), 32'd0);

    drive(1, 4'hA, 4'hA, 0);
    chk_a("agree", 4'hA, 1, 0, 0, 0, 2'd0, 2'd0);
    drive(0, 4'hF, 4'h0, 0);
    chk_a("idle_garbage", 4'hA, 0, 0, 0, 0, 2'd0, 2'd0);

    drive(1, 4'h3, 4'h7, 0);
    chk_a("glitch_mis", 4'hA, 0, 1, 1, 0, 2'd1, 2'd1);
    drive(0, 4'h1, 4'h2, 0);
    chk_a("retry_hold", 4'hA, 0, 0, 0, 0, 2'd1, 2'd1);
    drive(1, 4'h5, 4'h5, 0);
    chk_a("glitch_ok", 4'h5, 1, 0, 0, 0, 2'd1, 2'd0);

    drive(0, 4'h0, 4'h0, 1);
    chk_a("clear1", 4'h5, 0, 0, 0, 0, 2'd0, 2'd0);

    drive(1, 4'h1, 4'h2, 0);
    chk_a("esc1", 4'h5, 0, 1, 1, 0, 2'd1, 2'd1);
    drive(1, 4'h4, 4'h8, 0);
    chk_a("esc2", 4'h5, 0, 1, 1, 0, 2'd2, 2'd1);
    drive(1, 4'hC, 4'h3, 0);
    chk_a("esc3", 4'h5, 0, 0, 1, 1, 2'd3, 2'd2);

    drive(1, 4'h9, 4'h9, 0);
    chk_a("fault_match", 4'h5, 0, 0, 0, 1, 2'd3, 2'd2);
    for (int i = 0; i < 5; i++) begin
      drive(1, 4'(i), 4'(i + 1), 0);
      chk("sat.err", 32'(a_err), 32'd1);
      chk("sat.cnt", 32'(a_cnt), 32'd3);
    end
    chk_a("sat_end", 4'h5, 0, 0, 1, 1, 2'd3, 2'd2);

    drive(1, 4'h6, 4'h1, 1);
    chk_a("clear_mis", 4'h5, 0, 0, 0, 0, 2'd0, 2'd0);
    drive(1, 4'hE, 4'hE, 1);
    chk_a("clear_match", 4'h5, 0, 0, 0, 0, 2'd0, 2'd0);

    drive(1, 4'h2, 4'h3, 0);
    chk_a("pre_rst", 4'h5, 0, 1, 1, 0, 2'd1, 2'd1);
    valid_a = 1'b0;
    rst_n   = 1'b0;
    #1;
    chk_a("mid_rst", 4'h0, 0, 0, 0, 0, 2'd0, 2'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk_a("post_rst", 4'h0, 0, 0, 0, 0, 2'd0, 2'd0);

    valid_b = 1'b1;
    d0      = 4'h1;
    d1      = 4'h2;
    tick();
    valid_b = 1'b0;
    chk("mr0.state", 32'(b_state), 32'd2);
    chk("mr0.fault", 32'(b_fault), 32'd1);
    chk("mr0.retry", 32'(b_retry), 32'd0);
    chk("mr0.err",   32'(b_err),   32'd1);
    chk("mr0.cnt",   32'(b_cnt),   32'd1);
    chk("mr0.ov",    32'(b_ov),    32'd0);
    chk("mr0.out",   32'(b_out),   32'd0);
    tick();
    chk("mr0.err2",  32'(b_err),   32'd0);
    chk("mr0.fault2", 32'(b_fault), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
